// File: rtl/pam_pulse_detector.sv
// pam_pulse_detector: receive-side PAM frame recogniser.
// Finds "pulse, short gap, pulse" after a long quiet period and reports pulse widths,
// the inter-pulse gap and pulse peaks; malformed frames raise err with a code.
// Optional build macro: PAM_STATS_EN (pair/error counters; tied to 0 when undefined).
module pam_pulse_detector #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned THRESH    = 128,
    parameter int unsigned PULSE_LEN = 101,
    parameter int unsigned LEN_TOL   = 4,
    parameter int unsigned SHORT_GAP = 2000,
    parameter int unsigned GAP_TOL   = 16,
    parameter int unsigned MIN_QUIET = 90000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              pair_valid,
    output logic [CNT_W-1:0]  width1,
    output logic [CNT_W-1:0]  width2,
    output logic [CNT_W-1:0]  gap_len,
    output logic [DATA_W-1:0] peak1,
    output logic [DATA_W-1:0] peak2,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic [15:0]       pair_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic [DATA_W-1:0] ThreshV   = DATA_W'(THRESH);
    localparam logic [CNT_W-1:0]  WidthMin  = CNT_W'(PULSE_LEN - LEN_TOL);
    localparam logic [CNT_W-1:0]  WidthMax  = CNT_W'(PULSE_LEN + LEN_TOL);
    localparam logic [CNT_W-1:0]  GapMin    = CNT_W'(SHORT_GAP - GAP_TOL);
    localparam logic [CNT_W-1:0]  GapMax    = CNT_W'(SHORT_GAP + GAP_TOL);
    localparam logic [CNT_W-1:0]  QuietMin  = CNT_W'(MIN_QUIET);
    localparam logic [1:0]        ErrWidth  = 2'd1;
    localparam logic [1:0]        ErrGap    = 2'd2;

    typedef enum logic [1:0] {StSync, StP1, StG1, StP2} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   quiet_q;
    logic [CNT_W-1:0]   width_q;
    logic [CNT_W-1:0]   gap_q;
    logic [DATA_W-1:0]  peak_q;
    // First-pulse results are held privately so published fields change only with pair_valid.
    logic [CNT_W-1:0]   w1_q;
    logic [DATA_W-1:0]  p1_q;

    logic               is_high;
    logic [CNT_W-1:0]   width_inc;
    logic [CNT_W-1:0]   gap_inc;
    logic [DATA_W-1:0]  peak_max;
    logic               width_ok;

    // Sample classification and counter increments for the current sample
    always_comb begin
        is_high   = (sample >= ThreshV);
        width_inc = width_q + CNT_W'(1);
        gap_inc   = gap_q + CNT_W'(1);
        peak_max  = (sample > peak_q) ? sample : peak_q;
        width_ok  = (width_q >= WidthMin) && (width_q <= WidthMax);
    end

    assign busy = (state_q != StSync);

    // Frame FSM with registered strobes and result fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StSync;
            quiet_q    <= '0;
            width_q    <= '0;
            gap_q      <= '0;
            peak_q     <= '0;
            w1_q       <= '0;
            p1_q       <= '0;
            pair_valid <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            width1     <= '0;
            width2     <= '0;
            gap_len    <= '0;
            peak1      <= '0;
            peak2      <= '0;
        end else begin
            pair_valid <= 1'b0;
            err        <= 1'b0;
            if (sample_valid) begin
                case (state_q)
                    StSync: begin
                        if (!is_high) begin
                            if (quiet_q != '1) quiet_q <= quiet_q + CNT_W'(1);
                        end else if (quiet_q >= QuietMin) begin
                            state_q <= StP1;
                            width_q <= CNT_W'(1);
                            peak_q  <= sample;
                        end else begin
                            quiet_q <= '0;
                        end
                    end
                    StP1, StP2: begin
                        if (is_high) begin
                            if (width_inc > WidthMax) begin
                                err      <= 1'b1;
                                err_code <= ErrWidth;
                                state_q  <= StSync;
                                quiet_q  <= '0;
                            end else begin
                                width_q <= width_inc;
                                peak_q  <= peak_max;
                            end
                        end else if (!width_ok) begin
                            err      <= 1'b1;
                            err_code <= ErrWidth;
                            state_q  <= StSync;
                            quiet_q  <= '0;
                        end else if (state_q == StP1) begin
                            w1_q    <= width_q;
                            p1_q    <= peak_q;
                            gap_q   <= CNT_W'(1);
                            state_q <= StG1;
                        end else begin
                            width1     <= w1_q;
                            peak1      <= p1_q;
                            gap_len    <= gap_q;
                            width2     <= width_q;
                            peak2      <= peak_q;
                            pair_valid <= 1'b1;
                            state_q    <= StSync;
                            // The terminating low sample already counts toward the next quiet.
                            quiet_q    <= CNT_W'(1);
                        end
                    end
                    StG1: begin
                        if (!is_high) begin
                            if (gap_inc > GapMax) begin
                                err      <= 1'b1;
                                err_code <= ErrGap;
                                state_q  <= StSync;
                                quiet_q  <= '0;
                            end else begin
                                gap_q <= gap_inc;
                            end
                        end else if (gap_q >= GapMin) begin
                            state_q <= StP2;
                            width_q <= CNT_W'(1);
                            peak_q  <= sample;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ErrGap;
                            state_q  <= StSync;
                            quiet_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= StSync;
                        quiet_q <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PAM_STATS_EN
    // Wrapping event counters, stepped by the registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (pair_valid) pair_cnt <= pair_cnt + 16'd1;
            if (err)        err_cnt  <= err_cnt + 16'd1;
        end
    end
`else
    assign pair_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: doc/pam_pulse_detector.md
Name: pam_pulse_detector

Overview:
Receive-side counterpart of the PAM signal generator path. It consumes the digitised pulse stream (ADC samples) and recognises the transmitted frame: a pulse, a short gap, a second pulse, then a long quiet period. For each valid pulse pair it reports the pulse widths, the inter-pulse gap and the peak amplitudes. Malformed frames are flagged with an error code. It sits between the ADC sample interface and downstream DSP/telemetry logic.

Parameters:
DATA_W, 8, sample width (unsigned)
THRESH, 128, pulse threshold; a sample is "high" when sample >= THRESH
PULSE_LEN, 101, nominal pulse width in samples
LEN_TOL, 4, allowed +/- deviation of pulse width
SHORT_GAP, 2000, nominal inter-pulse gap in samples
GAP_TOL, 16, allowed +/- deviation of gap
MIN_QUIET, 90000, low samples required before the first pulse of a frame is accepted
CNT_W, 17, width of all length counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sample_valid  in  1  qualifies sample; logic advances only when high
sample  in  DATA_W  ADC sample, unsigned
pair_valid  out  1  one-cycle strobe: a valid pulse pair was received
width1  out  CNT_W  width of first pulse (samples)
width2  out  CNT_W  width of second pulse
gap_len  out  CNT_W  low samples between pulses
peak1  out  DATA_W  max sample inside first pulse
peak2  out  DATA_W  max sample inside second pulse
err  out  1  one-cycle strobe: frame rejected
err_code  out  2  1=width, 2=gap; held until next err
busy  out  1  high in states P1, G1, P2
pair_cnt  out  16  pairs received (see optional feature)
err_cnt  out  16  errors (see optional feature)

Behaviour:
- Reset (synchronous, active-high, honoured mid-frame): state SYNC, quiet counter 0; all outputs 0.
- Only cycles with sample_valid=1 advance state or counters. With sample_valid=0, everything holds and strobes are 0.
- States and transitions:
  - SYNC: a low sample increments quiet (saturating at 2^CNT_W-1). A high sample with quiet >= MIN_QUIET enters P1 with width=1 and peak=sample. A high sample with quiet < MIN_QUIET resets quiet to 0 and stays in SYNC.
  - P1: a high sample increments width and updates peak = max(peak, sample). A low sample ends the pulse:
    - If PULSE_LEN-LEN_TOL <= width <= PULSE_LEN+LEN_TOL, latch width1/peak1 and enter G1 with gap=1.
    - Otherwise raise a width error.
  - P1, P2: width exceeding PULSE_LEN+LEN_TOL raises a width error immediately on that sample, without waiting for the falling edge.
  - G1: a low sample increments gap. If gap exceeds SHORT_GAP+GAP_TOL, raise a gap error immediately. A high sample ends the gap:
    - If gap >= SHORT_GAP-GAP_TOL, latch gap_len and enter P2 with width=1 and peak=sample.
    - Otherwise raise a gap error.
  - P2: same as P1. On a valid falling edge, latch width2/peak2, assert pair_valid, and go to SYNC with quiet=1 (the terminating low sample counts toward the long quiet).
- Error action: assert err for one cycle, set err_code, go to SYNC with quiet=0. The width1/width2/gap_len/peak outputs keep their last valid values.
- Output timing: strobes are registered and appear the cycle after the deciding sample. Result fields update on the same edge as pair_valid and are stable until the next pair_valid.
- pair_valid and err never assert together.
- Threshold comparison is unsigned. Peaks start from the first high sample, never from 0.

Optional Feature:
PAM_STATS_EN
- Defined: pair_cnt increments on each pair_valid and err_cnt on each err. Both are 16-bit, wrap from 0xFFFF to 0, and clear on rst.
- Undefined: the counters are not built; pair_cnt and err_cnt are tied to 0. Ports are present either way.

Test Plan:
Bench parameters: PULSE_LEN=10, LEN_TOL=1, SHORT_GAP=20, GAP_TOL=2, MIN_QUIET=50, THRESH=128, all cycles valid.
- Nominal frame: 60 low, 10 high (peak 200), 20 low, 10 high (peak 180), 60 low -> one pair_valid the cycle after the 1st low following pulse 2; width1=10, width2=10, gap_len=20, peak1=200, peak2=180; a repeat frame yields a 2nd pair_valid.
- Insufficient quiet: 40 low then nominal pulses -> no pair_valid, no err; a following correct frame (which counts as >=50 low) is detected.
- Width error: after 60 low, pulse 1 of 12 high -> err on the cycle after the 12th high, err_code=1, busy=0; width of 8 -> err after the 1st low, err_code=1.
- Gap errors: gap of 23 low -> err after the 23rd low, err_code=2; gap of 17 followed by high -> err after that high, err_code=2.
- Valid gating and reset: nominal frame with sample_valid toggling 0/1 every cycle -> same results as the nominal case. Asserting rst during G1 -> next cycle all outputs 0 and busy=0; the frame after reset requires 50 fresh lows.
- With PAM_STATS_EN: 3 good frames + 1 width error -> pair_cnt=3, err_cnt=1. Without the macro, both read 0.
